retire_perf_monitor: RTL and testbench
======================================

RETIRE_PERF_MONITOR -- requirements
Module: retire_perf_monitor

Interface
REQ-001 SHALL have parameter CNT_WIDTH, 32, width of every counter (min 8).
REQ-002 SHALL have parameter NUM_EVENTS, 4, number of generic event counters (1-16).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, 400000, cycle count forcing TIMEOUT; 0 disables the watchdog.
REQ-004 SHALL have port i_clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port i_rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port i_start  input  1  begin a measurement run.
REQ-007 SHALL have port i_clear  input  1  synchronous clear of counters and state.
REQ-008 SHALL have port i_retire_valid  input  1  instruction retires this cycle.
REQ-009 SHALL have port i_retire_inst  input  32  retiring instruction word.
REQ-010 SHALL have port i_retire_halt  input  1  retiring instruction halts the hart.
REQ-011 SHALL have port i_retire_dmem_wen  input  1  retiring instruction is a store.
REQ-012 SHALL have port i_mispredict  input  1  EX-stage mispredict pulse.
REQ-013 SHALL have port i_event  input  NUM_EVENTS  generic event strobes.
REQ-014 SHALL have ports o_cycles, o_instret, o_branches, o_mispredicts, o_stores  output  CNT_WIDTH each  counter values.
REQ-015 SHALL have port o_events  output  NUM_EVENTS*CNT_WIDTH  event counter i at bits [i*CNT_WIDTH +: CNT_WIDTH].
REQ-016 SHALL have port o_state  output  2  00 IDLE, 01 RUN, 10 HALTED, 11 TIMEOUT.
REQ-017 SHALL have port o_done  output  1  high in HALTED or TIMEOUT.

Function
REQ-018 SHALL implement FSM IDLE->RUN on i_start in IDLE; RUN->HALTED on i_retire_valid&i_retire_halt; RUN->TIMEOUT when o_cycles reaches TIMEOUT_CYCLES; any state->IDLE on i_clear.
REQ-019 SHALL ignore i_start outside IDLE; HALTED and TIMEOUT are held until i_clear.
REQ-020 SHALL count only on edges where state is RUN; the i_start edge increments nothing.
REQ-021 SHALL increment o_cycles by 1 on every RUN edge, including the halting edge.
REQ-022 SHALL increment o_instret on i_retire_valid, including the halting instruction.
REQ-023 SHALL increment o_branches on i_retire_valid with i_retire_inst[6:0] in {1100011, 1101111, 1100111}.
REQ-024 SHALL increment o_mispredicts on i_mispredict regardless of i_retire_valid.
REQ-025 SHALL increment o_stores on i_retire_valid&i_retire_dmem_wen only.
REQ-026 SHALL increment event counter i on i_event[i].
REQ-027 SHALL give halt priority over timeout on the same edge (state HALTED).
REQ-028 SHALL give i_clear priority over i_start and all count events on the same edge.
REQ-029 SHALL drive all outputs directly from registers (zero combinational input-to-output paths).

Reset
REQ-030 SHALL on i_rst asynchronously set state IDLE, all counters 0, o_done 0.
REQ-031 SHALL on i_rst asserted mid-RUN discard the run; counting resumes only after a new i_start following deassertion.
REQ-032 SHALL make i_clear produce identical register values to i_rst, one edge later.

Configuration
REQ-033 SHALL with macro PERF_SATURATE_EN defined hold any counter at 2^CNT_WIDTH-1 instead of incrementing.
REQ-034 SHALL without PERF_SATURATE_EN wrap counters modulo 2^CNT_WIDTH; the watchdog compare SHALL remain exact in both modes.

Verification
REQ-035 SHALL cover: start, 10 RUN cycles, 6 retires (2 x 1100011, 1 store), halt on 6th -> cycles=10, instret=6, branches=2, stores=1, state=HALTED.
REQ-036 SHALL cover: TIMEOUT_CYCLES=20, no halt -> state=TIMEOUT with cycles=20 and counters frozen thereafter.
REQ-037 SHALL cover: halt retires on cycle 20 with TIMEOUT_CYCLES=20 -> state=HALTED.
REQ-038 SHALL cover: CNT_WIDTH=8, 300 events -> 255 with PERF_SATURATE_EN, 44 without.
REQ-039 SHALL cover: i_clear and i_start on same edge in HALTED -> IDLE, all counters 0; i_rst mid-RUN -> immediate IDLE, zeros.
REQ-040 SHALL cover: i_mispredict with i_retire_valid=0 and i_event=4'b1010 for 3 cycles -> mispredicts=3, events {0,3,0,3}.

Source files
------------

// File: rtl/retire_perf_monitor.sv
// Retirement performance monitor: run-control FSM plus cycle/instret/branch/mispredict/store/event counters.
// Define PERF_SATURATE_EN to make counters saturate at all-ones instead of wrapping.
module retire_perf_monitor #(
    parameter int CNT_WIDTH      = 32,
    parameter int NUM_EVENTS     = 4,
    parameter int TIMEOUT_CYCLES = 400000
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_start,
    input  logic                             i_clear,
    input  logic                             i_retire_valid,
    input  logic [31:0]                      i_retire_inst,
    input  logic                             i_retire_halt,
    input  logic                             i_retire_dmem_wen,
    input  logic                             i_mispredict,
    input  logic [NUM_EVENTS-1:0]            i_event,
    output logic [CNT_WIDTH-1:0]             o_cycles,
    output logic [CNT_WIDTH-1:0]             o_instret,
    output logic [CNT_WIDTH-1:0]             o_branches,
    output logic [CNT_WIDTH-1:0]             o_mispredicts,
    output logic [CNT_WIDTH-1:0]             o_stores,
    output logic [NUM_EVENTS*CNT_WIDTH-1:0]  o_events,
    output logic [1:0]                       o_state,
    output logic                             o_done
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_RUN     = 2'b01,
        S_HALTED  = 2'b10,
        S_TIMEOUT = 2'b11
    } state_t;

    // The watchdog has its own counter sized to the limit so it stays exact even when o_cycles wraps or saturates.
    localparam int WD_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    state_t                          state_q, state_d;
    logic                            done_q, done_d;
    logic [WD_W-1:0]                 wd_q, wd_d;
    logic [CNT_WIDTH-1:0]            cycles_q, cycles_d;
    logic [CNT_WIDTH-1:0]            instret_q, instret_d;
    logic [CNT_WIDTH-1:0]            branches_q, branches_d;
    logic [CNT_WIDTH-1:0]            mispredicts_q, mispredicts_d;
    logic [CNT_WIDTH-1:0]            stores_q, stores_d;
    logic [NUM_EVENTS*CNT_WIDTH-1:0] events_q, events_d;
    logic                            is_branch;
    logic                            unused_inst;

    function automatic logic [CNT_WIDTH-1:0] cnt_inc(input logic [CNT_WIDTH-1:0] v);
`ifdef PERF_SATURATE_EN
        return (&v) ? v : v + 1'b1;
`else
        return v + 1'b1;
`endif
    endfunction

    // Conditional branches, JAL and JALR all count as branches.
    assign is_branch = (i_retire_inst[6:0] == 7'b1100011) ||
                       (i_retire_inst[6:0] == 7'b1101111) ||
                       (i_retire_inst[6:0] == 7'b1100111);
    assign unused_inst = ^i_retire_inst[31:7];

    always_comb begin
        state_d       = state_q;
        done_d        = done_q;
        wd_d          = wd_q;
        cycles_d      = cycles_q;
        instret_d     = instret_q;
        branches_d    = branches_q;
        mispredicts_d = mispredicts_q;
        stores_d      = stores_q;
        events_d      = events_q;
        if (i_clear) begin
            state_d       = S_IDLE;
            done_d        = 1'b0;
            wd_d          = '0;
            cycles_d      = '0;
            instret_d     = '0;
            branches_d    = '0;
            mispredicts_d = '0;
            stores_d      = '0;
            events_d      = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        state_d = S_RUN;
                        wd_d    = '0;
                    end
                end
                S_RUN: begin
                    cycles_d = cnt_inc(cycles_q);
                    if (TIMEOUT_CYCLES != 0) wd_d = wd_q + 1'b1;
                    if (i_retire_valid) instret_d = cnt_inc(instret_q);
                    if (i_retire_valid && is_branch) branches_d = cnt_inc(branches_q);
                    if (i_mispredict) mispredicts_d = cnt_inc(mispredicts_q);
                    if (i_retire_valid && i_retire_dmem_wen) stores_d = cnt_inc(stores_q);
                    for (int i = 0; i < NUM_EVENTS; i++) begin
                        if (i_event[i])
                            events_d[i*CNT_WIDTH +: CNT_WIDTH] = cnt_inc(events_q[i*CNT_WIDTH +: CNT_WIDTH]);
                    end
                    // Halt wins over a timeout landing on the same edge.
                    if (i_retire_valid && i_retire_halt) begin
                        state_d = S_HALTED;
                        done_d  = 1'b1;
                    end else if (TIMEOUT_CYCLES != 0 && wd_q == WD_LAST) begin
                        state_d = S_TIMEOUT;
                        done_d  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q       <= S_IDLE;
            done_q        <= 1'b0;
            wd_q          <= '0;
            cycles_q      <= '0;
            instret_q     <= '0;
            branches_q    <= '0;
            mispredicts_q <= '0;
            stores_q      <= '0;
            events_q      <= '0;
        end else begin
            state_q       <= state_d;
            done_q        <= done_d;
            wd_q          <= wd_d;
            cycles_q      <= cycles_d;
            instret_q     <= instret_d;
            branches_q    <= branches_d;
            mispredicts_q <= mispredicts_d;
            stores_q      <= stores_d;
            events_q      <= events_d;
        end
    end

    assign o_cycles      = cycles_q;
    assign o_instret     = instret_q;
    assign o_branches    = branches_q;
    assign o_mispredicts = mispredicts_q;
    assign o_stores      = stores_q;
    assign o_events      = events_q;
    assign o_state       = state_q;
    assign o_done        = done_q;

endmodule

// File: tb/tb_retire_perf_monitor.sv
// Scoreboard bench for retire_perf_monitor: a CNT_WIDTH=8/TIMEOUT=20 instance checked every edge
// against a reference model, and a watchdog-free instance for the wrap/saturate case.
module tb_retire_perf_monitor;

    localparam int TO = 20;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] BEQ   = 32'h0000_0063;
    localparam logic [31:0] STORE = 32'h0000_2023;
    localparam logic [31:0] ADD   = 32'h0000_0033;
    localparam logic [31:0] JAL   = 32'h0000_006F;
    localparam logic [31:0] JALR  = 32'h0000_0067;
    localparam logic [31:0] ECALL = 32'h0000_0073;

    logic        clk = 1'b0;
    logic        rst, start, clear, valid, halt, wen, misp;
    logic [31:0] inst;
    logic [3:0]  ev;

    logic [7:0]  a_cycles, a_instret, a_branches, a_mispredicts, a_stores;
    logic [31:0] a_events;
    logic [1:0]  a_state;
    logic        a_done;
    logic [7:0]  b_cycles, b_instret, b_branches, b_mispredicts, b_stores;
    logic [31:0] b_events;
    logic [1:0]  b_state;
    logic        b_done;

    always #5 clk = ~clk;

    retire_perf_monitor #(.CNT_WIDTH(8), .NUM_EVENTS(4), .TIMEOUT_CYCLES(TO)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_clear(clear),
        .i_retire_valid(valid), .i_retire_inst(inst), .i_retire_halt(halt),
        .i_retire_dmem_wen(wen), .i_mispredict(misp), .i_event(ev),
        .o_cycles(a_cycles), .o_instret(a_instret), .o_branches(a_branches),
        .o_mispredicts(a_mispredicts), .o_stores(a_stores), .o_events(a_events),
        .o_state(a_state), .o_done(a_done)
    );

    retire_perf_monitor #(.CNT_WIDTH(8), .NUM_EVENTS(4), .TIMEOUT_CYCLES(0)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_clear(clear),
        .i_retire_valid(valid), .i_retire_inst(inst), .i_retire_halt(halt),
        .i_retire_dmem_wen(wen), .i_mispredict(misp), .i_event(ev),
        .o_cycles(b_cycles), .o_instret(b_instret), .o_branches(b_branches),
        .o_mispredicts(b_mispredicts), .o_stores(b_stores), .o_events(b_events),
        .o_state(b_state), .o_done(b_done)
    );

    typedef struct {
        logic [1:0]  st;
        logic        done;
        logic [7:0]  cyc, ins, br, mp, sto;
        logic [31:0] evs;
    } snap_t;

    snap_t sbq[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    // Reference model of dut_a
    logic [1:0] m_state;
    logic [7:0] m_cyc, m_ins, m_br, m_mp, m_st;
    logic [7:0] m_ev[4];
    int         m_raw;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] f_inc(input logic [7:0] v);
`ifdef PERF_SATURATE_EN
        return (v == 8'hFF) ? v : v + 8'd1;
`else
        return v + 8'd1;
`endif
    endfunction

    task automatic model_zero();
        m_state = 2'b00;
        m_cyc = 0; m_ins = 0; m_br = 0; m_mp = 0; m_st = 0; m_raw = 0;
        for (int i = 0; i < 4; i++) m_ev[i] = 0;
    endtask

    task automatic model_edge();
        logic [6:0] op;
        op = inst[6:0];
        if (clear) begin
            model_zero();
        end else if (m_state == 2'b00) begin
            if (start) begin
                m_state = 2'b01;
                m_raw   = 0;
            end
        end else if (m_state == 2'b01) begin
            m_cyc = f_inc(m_cyc);
            m_raw++;
            if (valid) m_ins = f_inc(m_ins);
            if (valid && (op == 7'h63 || op == 7'h6F || op == 7'h67)) m_br = f_inc(m_br);
            if (misp) m_mp = f_inc(m_mp);
            if (valid && wen) m_st = f_inc(m_st);
            for (int i = 0; i < 4; i++) if (ev[i]) m_ev[i] = f_inc(m_ev[i]);
            if (valid && halt) m_state = 2'b10;
            else if (m_raw == TO) m_state = 2'b11;
        end
    endtask

    task automatic push_expect();
        snap_t s;
        s.st   = m_state;
        s.done = (m_state == 2'b10) || (m_state == 2'b11);
        s.cyc  = m_cyc; s.ins = m_ins; s.br = m_br; s.mp = m_mp; s.sto = m_st;
        s.evs  = {m_ev[3], m_ev[2], m_ev[1], m_ev[0]};
        sbq.push_back(s);
    endtask

    task automatic pop_check();
        snap_t s;
        s = sbq.pop_front();
        chk("state",       a_state,       s.st);
        chk("done",        a_done,        s.done);
        chk("cycles",      a_cycles,      s.cyc);
        chk("instret",     a_instret,     s.ins);
        chk("branches",    a_branches,    s.br);
        chk("mispredicts", a_mispredicts, s.mp);
        chk("stores",      a_stores,      s.sto);
        chk("events",      a_events,      s.evs);
    endtask

    task automatic step(input logic s, input logic c, input logic v, input logic [31:0] in,
                        input logic h, input logic w, input logic m, input logic [3:0] e);
        start = s; clear = c; valid = v; inst = in; halt = h; wen = w; misp = m; ev = e;
        model_edge();
        push_expect();
        @(posedge clk);
        #1;
        pop_check();
    endtask

    task automatic idle_step();
        step(1'b0, 1'b0, 1'b0, NOP, 1'b0, 1'b0, 1'b0, 4'h0);
    endtask

    initial begin
        rst = 1'b1; start = 0; clear = 0; valid = 0; inst = NOP; halt = 0; wen = 0; misp = 0; ev = 0;
        model_zero();
        repeat (2) @(posedge clk);
        #1;
        push_expect();
        pop_check();
        chk("rst_b_state", b_state, 2'b00);
        chk("rst_b_cycles", b_cycles, 8'd0);
        rst = 1'b0;

        // Ten-cycle run ending in a halt on the sixth retire
        step(1, 0, 0, NOP, 0, 0, 0, 4'h0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, BEQ, 0, 1, 0, 4'h0);
        step(0, 0, 1, BEQ,   0, 0, 0, 4'h0);
        step(0, 0, 1, BEQ,   0, 0, 0, 4'h0);
        step(0, 0, 1, STORE, 0, 1, 0, 4'h0);
        step(0, 0, 1, ADD,   0, 0, 0, 4'h0);
        step(0, 0, 1, NOP,   0, 0, 0, 4'h0);
        step(0, 0, 1, ECALL, 1, 0, 0, 4'h0);
        chk("halt_cycles", a_cycles, 8'd10);
        chk("halt_instret", a_instret, 8'd6);
        chk("halt_branches", a_branches, 8'd2);
        chk("halt_stores", a_stores, 8'd1);
        chk("halt_state", a_state, 2'b10);
        chk("halt_done", a_done, 1'b1);
        step(1, 0, 1, BEQ, 0, 1, 1, 4'hF);
        chk("halt_hold_state", a_state, 2'b10);
        chk("halt_hold_cycles", a_cycles, 8'd10);
        step(1, 1, 1, BEQ, 0, 1, 1, 4'hF);
        chk("clr_start_state", a_state, 2'b00);
        chk("clr_start_cycles", a_cycles, 8'd0);
        chk("clr_start_instret", a_instret, 8'd0);
        chk("clr_start_done", a_done, 1'b0);

        // Mispredicts/events without retires, jumps, then watchdog expiry
        step(1, 0, 0, NOP, 0, 0, 0, 4'h0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, BEQ, 0, 0, 1, 4'b1010);
        chk("misp_count", a_mispredicts, 8'd3);
        chk("misp_events", a_events, 32'h0300_0300);
        chk("misp_instret", a_instret, 8'd0);
        step(0, 0, 1, JAL,  0, 0, 0, 4'h0);
        step(0, 0, 1, JALR, 0, 0, 0, 4'h0);
        chk("jump_branches", a_branches, 8'd2);
        for (int i = 0; i < 14; i++) idle_step();
        chk("pre_to_state", a_state, 2'b01);
        idle_step();
        chk("to_state", a_state, 2'b11);
        chk("to_cycles", a_cycles, 8'd20);
        chk("to_done", a_done, 1'b1);
        for (int i = 0; i < 3; i++) step(1, 0, 1, BEQ, 0, 1, 1, 4'hF);
        chk("to_frozen_cycles", a_cycles, 8'd20);
        chk("to_frozen_misp", a_mispredicts, 8'd3);
        chk("to_frozen_state", a_state, 2'b11);

        // Halt on the same edge the watchdog expires
        step(0, 1, 0, NOP, 0, 0, 0, 4'h0);
        step(1, 0, 0, NOP, 0, 0, 0, 4'h0);
        for (int i = 0; i < 19; i++) step(0, 0, 1, NOP, 0, 0, 0, 4'h0);
        step(0, 0, 1, ECALL, 1, 0, 0, 4'h0);
        chk("tie_state", a_state, 2'b10);
        chk("tie_cycles", a_cycles, 8'd20);

        // Asynchronous reset in the middle of a run
        step(0, 1, 0, NOP, 0, 0, 0, 4'h0);
        step(1, 0, 0, NOP, 0, 0, 0, 4'h0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, BEQ, 0, 1, 1, 4'h5);
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_zero();
        push_expect();
        pop_check();
        chk("arst_state", a_state, 2'b00);
        chk("arst_cycles", a_cycles, 8'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step(0, 0, 1, BEQ, 0, 1, 1, 4'h5);
        chk("post_rst_idle", a_state, 2'b00);
        chk("post_rst_cycles", a_cycles, 8'd0);
        step(1, 0, 0, NOP, 0, 0, 0, 4'h0);
        step(0, 0, 1, NOP, 0, 0, 0, 4'h0);
        step(0, 0, 1, NOP, 0, 0, 0, 4'h0);
        chk("restart_cycles", a_cycles, 8'd2);

        // 300 events on the watchdog-free instance: wrap or saturate
        step(0, 1, 0, NOP, 0, 0, 0, 4'h0);
        step(1, 0, 0, NOP, 0, 0, 0, 4'h0);
        for (int i = 0; i < 300; i++) step(0, 0, 0, NOP, 0, 0, 0, 4'b0001);
`ifdef PERF_SATURATE_EN
        chk("sat_b_cycles", b_cycles, 8'd255);
        chk("sat_b_event0", b_events[7:0], 8'd255);
`else
        chk("wrap_b_cycles", b_cycles, 8'd44);
        chk("wrap_b_event0", b_events[7:0], 8'd44);
`endif
        chk("big_b_state", b_state, 2'b01);
        chk("big_b_done", b_done, 1'b0);
        chk("big_a_state", a_state, 2'b11);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
